// File: rtl/window_pkg.sv
// Shared types and constants for the 3x3 window generator.
// Holds pixel/window widths, the bit offsets of the nine window slots and the
// control state type. No ports; imported by window_3x3_gen and line_buffer.
package window_pkg;

    localparam int PIX_W = 12;
    localparam int WIN_W = 108;

    // Slot offsets inside color_data (each slot is PIX_W bits wide).
    localparam int ORIG_LSB  = 96;
    localparam int LEFT_LSB  = 84;
    localparam int RIGHT_LSB = 72;
    localparam int UP_LSB    = 60;
    localparam int DOWN_LSB  = 48;
    localparam int UL_LSB    = 36;
    localparam int UR_LSB    = 24;
    localparam int DL_LSB    = 12;
    localparam int DR_LSB    = 0;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        FLUSH
    } state_e;

    // Maps a window position (row 0=up..2=down, col 0=left..2=right) to the
    // LSB of its slot in color_data.
    function automatic int slot_lsb(input int r, input int c);
        int lsb;
        case (r * 3 + c)
            0:       lsb = UL_LSB;
            1:       lsb = UP_LSB;
            2:       lsb = UR_LSB;
            3:       lsb = LEFT_LSB;
            4:       lsb = ORIG_LSB;
            5:       lsb = RIGHT_LSB;
            6:       lsb = DL_LSB;
            7:       lsb = DOWN_LSB;
            default: lsb = DR_LSB;
        endcase
        return lsb;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-line pixel store: one write port, one registered read port.
// Latency: read data appears one clock after the read address is presented.
// Backpressure: none; the owner gates writes with wr_en_i.
// Ports: clk; wr_en_i/wr_addr_i/wr_dat_i write port; rd_addr_i/rd_dat_o read port.
module line_buffer
    import window_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [PIX_W-1:0] wr_dat_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [PIX_W-1:0] rd_dat_o
);

    // Contents are never cleared: stale entries are only ever read for
    // out-of-frame neighbours, which the window logic masks.
    logic [PIX_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
        rd_dat_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood generator for a raster RGB444 stream (two line buffers + 3x3 regs).
// Latency: window for raster index n is emitted one clock after index n+IMG_WIDTH+1
// is accepted (or the matching flush cycle). Backpressure: in_ready drops for the
// IMG_WIDTH+1 flush cycles at frame end; pixel_valid gaps freeze all state.
// Ports: clk, reset (async, high); pixel_in/pixel_valid/frame_start input stream;
// in_ready; color_data/window_valid/win_last output windows.
// Build option: define BORDER_REPLICATE_EN for edge-clamp borders (default: zero border).
module window_3x3_gen
    import window_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             pixel_valid,
    input  logic             frame_start,
    output logic             in_ready,
    output logic [WIN_W-1:0] color_data,
    output logic             window_valid,
    output logic             win_last
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int NW = $clog2(IMG_WIDTH + 2);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [NW-1:0] CNT_LAST = NW'(IMG_WIDTH);

    state_e                     state_q, state_d;
    logic [NW-1:0]              cnt_q, cnt_d;
    logic [CW-1:0]              in_col_q, in_col_d, wr_col;
    logic [RW-1:0]              in_row_q, in_row_d;
    logic [CW-1:0]              out_col_q, out_col_d;
    logic [RW-1:0]              out_row_q, out_row_d;
    logic                       accept, adv, emit;
    logic [PIX_W-1:0]           down_pix, lb0_rd, lb1_rd;
    logic [2:0][2:0][PIX_W-1:0] raw_q, raw_d;
    logic [WIN_W-1:0]           color_q, color_d;
    logic                       valid_q, last_q;
    logic                       top, bot, lft, rgt;

    assign in_ready     = (state_q != FLUSH);
    assign accept       = pixel_valid && in_ready;
    assign color_data   = color_q;
    assign window_valid = valid_q;
    assign win_last     = last_q;

    // adv: the raster pipeline shifts by one (accepted pixel or flush cycle).
    // emit: that shift completes a window.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_col_d  = in_col_q;
        in_row_d  = in_row_q;
        out_col_d = out_col_q;
        out_row_d = out_row_q;
        wr_col    = in_col_q;
        adv       = 1'b0;
        emit      = 1'b0;
        if (accept && frame_start) begin
            // New frame from any state: this pixel becomes (0,0).
            state_d   = FILL;
            cnt_d     = NW'(1);
            wr_col    = '0;
            in_col_d  = CW'(1);
            in_row_d  = '0;
            out_col_d = '0;
            out_row_d = '0;
            adv       = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    // Pixels without frame_start are dropped here.
                end
                FILL: begin
                    if (accept) begin
                        adv   = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) state_d = STREAM;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        adv  = 1'b1;
                        emit = 1'b1;
                        if (in_col_q == COL_LAST && in_row_q == ROW_LAST) begin
                            state_d = FLUSH;
                            cnt_d   = '0;
                        end
                    end
                end
                FLUSH: begin
                    adv   = 1'b1;
                    emit  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (adv) begin
                in_col_d = (in_col_q == COL_LAST) ? '0 : in_col_q + 1'b1;
                if (in_col_q == COL_LAST) begin
                    in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + 1'b1;
                end
            end
            if (emit) begin
                out_col_d = (out_col_q == COL_LAST) ? '0 : out_col_q + 1'b1;
                if (out_col_q == COL_LAST) begin
                    out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + 1'b1;
                end
            end
        end
    end

    // Flush cycles feed zeros; that row lies below the frame and is masked anyway.
    assign down_pix = (state_q == FLUSH) ? '0 : pixel_in;

    // Both buffers are read at the column about to be written next, so the
    // registered read data is ready when that pixel arrives. lb0 delays by one
    // line, lb1 (fed from lb0) by two.
    line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb0 (
        .clk       (clk),
        .wr_en_i   (adv),
        .wr_addr_i (wr_col),
        .wr_dat_i  (down_pix),
        .rd_addr_i (in_col_d),
        .rd_dat_o  (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb1 (
        .clk       (clk),
        .wr_en_i   (adv),
        .wr_addr_i (wr_col),
        .wr_dat_i  (lb0_rd),
        .rd_addr_i (in_col_d),
        .rd_dat_o  (lb1_rd)
    );

    // raw_q[row][col]: row 0=up, 2=down; col 0=left, 2=right (newest).
    always_comb begin
        raw_d = raw_q;
        if (adv) begin
            for (int r = 0; r < 3; r++) begin
                raw_d[r][0] = raw_q[r][1];
                raw_d[r][1] = raw_q[r][2];
            end
            raw_d[0][2] = lb1_rd;
            raw_d[1][2] = lb0_rd;
            raw_d[2][2] = down_pix;
        end
    end

    assign top = (out_row_q == '0);
    assign bot = (out_row_q == ROW_LAST);
    assign lft = (out_col_q == '0);
    assign rgt = (out_col_q == COL_LAST);

    // Border handling is decided from the centre position only, so the wrapped
    // neighbour from the adjacent line is never passed through.
    always_comb begin
`ifdef BORDER_REPLICATE_EN
        int sr;
        int sc;
`endif
        color_d = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
`ifdef BORDER_REPLICATE_EN
                sr = r;
                sc = c;
                if ((r == 0 && top) || (r == 2 && bot)) sr = 1;
                if ((c == 0 && lft) || (c == 2 && rgt)) sc = 1;
                color_d[slot_lsb(r, c) +: PIX_W] = raw_d[sr][sc];
`else
                if (!((r == 0 && top) || (r == 2 && bot) ||
                      (c == 0 && lft) || (c == 2 && rgt))) begin
                    color_d[slot_lsb(r, c) +: PIX_W] = raw_d[r][c];
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            in_col_q  <= '0;
            in_row_q  <= '0;
            out_col_q <= '0;
            out_row_q <= '0;
            raw_q     <= '0;
            color_q   <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            in_col_q  <= in_col_d;
            in_row_q  <= in_row_d;
            out_col_q <= out_col_d;
            out_row_q <= out_row_d;
            raw_q     <= raw_d;
            valid_q   <= emit;
            last_q    <= emit && rgt && bot;
            if (emit) color_q <= color_d;
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
module tb_window_3x3_gen;

    localparam int W = 4;
    localparam int H = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [11:0]  pixel_in = '0;
    logic         pixel_valid = 1'b0;
    logic         frame_start = 1'b0;
    logic         in_ready;
    logic [107:0] color_data;
    logic         window_valid;
    logic         win_last;

    window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk          (clk),
        .reset        (reset),
        .pixel_in     (pixel_in),
        .pixel_valid  (pixel_valid),
        .frame_start  (frame_start),
        .in_ready     (in_ready),
        .color_data   (color_data),
        .window_valid (window_valid),
        .win_last     (win_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0]  pix;
        logic [107:0] win;
        logic         last;
    } vec_t;

    vec_t         tbl[12];
    logic [107:0] q_win[$];
    logic         q_last[$];
    int           rdy_low = 0;
    int           n_checks = 0;
    int           n_fail = 0;

    // Window collector, sampled on the falling edge.
    always @(negedge clk) begin
        if (window_valid) begin
            q_win.push_back(color_data);
            q_last.push_back(win_last);
        end
        if (!in_ready) rdy_low++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Slot order: original, left, right, up, down, upleft, upright, downleft, downright.
    function automatic logic [107:0] pk(input int o, l, r, u, d, ul, ur, dl, dr);
        return {12'(o), 12'(l), 12'(r), 12'(u), 12'(d), 12'(ul), 12'(ur), 12'(dl), 12'(dr)};
    endfunction

    task automatic chk(input string nm, input logic [107:0] act, input logic [107:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Presents one pixel and returns on the falling edge after it is accepted.
    task automatic send(input int p, input bit fs);
        int n;
        n = 0;
        pixel_in    = 12'(p);
        frame_start = fs;
        pixel_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: in_ready=%0d required 1", in_ready);
        end
        @(negedge clk);
        pixel_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic check_windows(input string nm, input int base, input int start, input int n);
        for (int k = 0; k < n; k++) begin
            if (base + k < q_win.size()) begin
                chk($sformatf("%s_win%0d", nm, start + k), q_win[base + k], tbl[start + k].win);
                chk($sformatf("%s_last%0d", nm, start + k), 108'(q_last[base + k]), 108'(tbl[start + k].last));
            end else begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_missing%0d: got %0d windows required %0d", nm, start + k, q_win.size() - base, n);
            end
        end
    endtask

    initial begin
        int base;
        int rb;

        for (int i = 0; i < 12; i++) begin
            tbl[i].pix  = 12'(i);
            tbl[i].last = (i == 11);
        end
`ifdef BORDER_REPLICATE_EN
        tbl[0].win  = pk(0, 0, 1, 0, 4, 0, 1, 4, 5);
        tbl[1].win  = pk(1, 0, 2, 1, 5, 0, 2, 4, 6);
        tbl[2].win  = pk(2, 1, 3, 2, 6, 1, 3, 5, 7);
        tbl[3].win  = pk(3, 2, 3, 3, 7, 2, 3, 6, 7);
        tbl[4].win  = pk(4, 4, 5, 0, 8, 0, 1, 8, 9);
        tbl[5].win  = pk(5, 4, 6, 1, 9, 0, 2, 8, 10);
        tbl[6].win  = pk(6, 5, 7, 2, 10, 1, 3, 9, 11);
        tbl[7].win  = pk(7, 6, 7, 3, 11, 2, 3, 10, 11);
        tbl[8].win  = pk(8, 8, 9, 4, 8, 4, 5, 8, 9);
        tbl[9].win  = pk(9, 8, 10, 5, 9, 4, 6, 8, 10);
        tbl[10].win = pk(10, 9, 11, 6, 10, 5, 7, 9, 11);
        tbl[11].win = pk(11, 10, 11, 7, 11, 6, 7, 10, 11);
`else
        tbl[0].win  = pk(0, 0, 1, 0, 4, 0, 0, 0, 5);
        tbl[1].win  = pk(1, 0, 2, 0, 5, 0, 0, 4, 6);
        tbl[2].win  = pk(2, 1, 3, 0, 6, 0, 0, 5, 7);
        tbl[3].win  = pk(3, 2, 0, 0, 7, 0, 0, 6, 0);
        tbl[4].win  = pk(4, 0, 5, 0, 8, 0, 1, 0, 9);
        tbl[5].win  = pk(5, 4, 6, 1, 9, 0, 2, 8, 10);
        tbl[6].win  = pk(6, 5, 7, 2, 10, 1, 3, 9, 11);
        tbl[7].win  = pk(7, 6, 0, 3, 11, 2, 0, 10, 0);
        tbl[8].win  = pk(8, 0, 9, 4, 0, 0, 5, 0, 0);
        tbl[9].win  = pk(9, 8, 10, 5, 0, 4, 6, 0, 0);
        tbl[10].win = pk(10, 9, 11, 6, 0, 5, 7, 0, 0);
        tbl[11].win = pk(11, 10, 0, 7, 0, 6, 0, 0, 0);
`endif

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_color", color_data, '0);
        chk("rst_valid", 108'(window_valid), 108'(0));
        chk("rst_last", 108'(win_last), 108'(0));
        chk("rst_in_ready", 108'(in_ready), 108'(1));
        reset = 1'b0;
        @(negedge clk);

        // Gap-free frame: timing of first window, count, in_ready low span.
        base = q_win.size();
        rb   = rdy_low;
        for (int i = 0; i < 12; i++) begin
            send(int'(tbl[i].pix), i == 0);
            if (i == 4) chk("no_win_before_idx5", 108'(window_valid), 108'(0));
            if (i == 5) chk("first_win_after_idx5", 108'(window_valid), 108'(1));
        end
        idle(15);
        chk("frame_count", 108'(q_win.size() - base), 108'(12));
        chk("flush_in_ready_low", 108'(rdy_low - rb), 108'(W + 1));
        check_windows("frame", base, 0, 12);

        // Same frame with random input gaps.
        base = q_win.size();
        for (int i = 0; i < 12; i++) begin
            send(int'(tbl[i].pix), i == 0);
            idle($urandom_range(0, 3));
        end
        idle(15);
        chk("gap_count", 108'(q_win.size() - base), 108'(12));
        check_windows("gap", base, 0, 12);

        // frame_start at index 7 restarts the frame.
        base = q_win.size();
        for (int i = 0; i < 7; i++) send(i, i == 0);
        for (int i = 0; i < 12; i++) begin
            send(i, i == 0);
            if (i == 4) chk("abort_no_win_yet", 108'(q_win.size() - base), 108'(2));
        end
        idle(15);
        chk("abort_count", 108'(q_win.size() - base), 108'(14));
        check_windows("abort_old", base, 0, 2);
        check_windows("abort_new", base + 2, 0, 12);

        // Reset after index 7.
        base = q_win.size();
        for (int i = 0; i < 8; i++) send(i, i == 0);
        reset = 1'b1;
        #1;
        chk("midrst_color", color_data, '0);
        chk("midrst_valid", 108'(window_valid), 108'(0));
        chk("midrst_last", 108'(win_last), 108'(0));
        chk("midrst_in_ready", 108'(in_ready), 108'(1));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 8; i < 12; i++) send(i, 1'b0);
        idle(10);
        chk("midrst_no_more_win", 108'(q_win.size() - base), 108'(3));
        for (int i = 0; i < 12; i++) send(i, i == 0);
        idle(15);
        chk("midrst_count", 108'(q_win.size() - base), 108'(15));
        check_windows("midrst_old", base, 0, 3);
        check_windows("midrst_new", base + 3, 0, 12);

        // frame_start coincident with the final pixel of a frame.
        base = q_win.size();
        for (int i = 0; i < 11; i++) send(i, i == 0);
        for (int i = 0; i < 12; i++) send(i, i == 0);
        idle(15);
        chk("lastfs_count", 108'(q_win.size() - base), 108'(18));
        check_windows("lastfs_old", base, 0, 6);
        check_windows("lastfs_new", base + 6, 0, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/window_3x3_gen.md
WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

Interface
REQ-001 Parameter IMG_WIDTH, default 640: active pixels per line; legal range 3..2048.
REQ-002 Parameter IMG_HEIGHT, default 480: lines per frame; legal range 3..2048.
REQ-003 clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pixel_in  input  12  RGB444 raster pixel: R[11:8], G[7:4], B[3:0].
REQ-006 pixel_valid  input  1  pixel_in is valid this cycle.
REQ-007 frame_start  input  1  qualified by pixel_valid; marks pixel (0,0) of a frame.
REQ-008 in_ready  output  1  block accepts input; a transfer occurs when pixel_valid && in_ready.
REQ-009 color_data  output  108  3x3 neighbourhood. original[107:96], left[95:84], right[83:72], up[71:60], down[59:48], upleft[47:36], upright[35:24], downleft[23:12], downright[11:0].
REQ-010 window_valid  output  1  color_data holds a new window this cycle (one-cycle pulse per window).
REQ-011 win_last  output  1  asserted with window_valid on the final window (IMG_WIDTH-1, IMG_HEIGHT-1) of a frame.

Function
REQ-012 The block shall buffer the two previous lines in two IMG_WIDTH x 12 line buffers, plus a 3x3 register window.
REQ-013 State machine states: IDLE, FILL, STREAM, FLUSH.
- IDLE -> FILL on an accepted pixel with frame_start.
- FILL -> STREAM after IMG_WIDTH+1 accepted pixels.
- STREAM -> FLUSH after pixel (IMG_WIDTH-1, IMG_HEIGHT-1) is accepted.
- FLUSH -> IDLE after IMG_WIDTH+1 flush cycles.
REQ-014 In IDLE, accepted pixels without frame_start shall be discarded.
REQ-015 in_ready shall be 1 in IDLE, FILL and STREAM, and 0 in FLUSH.
REQ-016 Each accepted pixel in STREAM and each FLUSH cycle shall produce exactly one window, registered one cycle later, centred on raster index (accepted index - IMG_WIDTH - 1); windows are emitted in raster order.
REQ-017 Exactly IMG_WIDTH*IMG_HEIGHT windows shall be emitted per frame.
REQ-018 Neighbours outside the frame (column -1 or IMG_WIDTH; row -1 or IMG_HEIGHT) shall be replaced by the border value (REQ-025/026). The column after IMG_WIDTH-1 must never take the next line's pixel.
REQ-019 Column and row counters shall wrap at IMG_WIDTH-1 and IMG_HEIGHT-1 respectively, with no off-by-one at line ends.
REQ-020 Gaps (pixel_valid low) shall freeze all state; window_valid stays 0 during a gap.
REQ-021 frame_start on an accepted pixel in FILL, STREAM or FLUSH shall abort the current frame: no further windows of the old frame, counters cleared, state = FILL with that pixel taken as (0,0).
REQ-022 frame_start coincident with the final pixel of a frame shall be handled as an abort (REQ-021).

Reset
REQ-023 While reset is high: color_data=0, window_valid=0, win_last=0, in_ready=1, state=IDLE, all counters=0. Line buffer contents need not be cleared.
REQ-024 Reset asserted mid-frame shall discard the frame; the first window after reset shall come from a new frame_start.

Configuration
REQ-025 With BORDER_REPLICATE_EN defined, out-of-frame neighbours shall take the value of the nearest in-frame pixel (edge clamp; corners take the corner pixel).
REQ-026 Without BORDER_REPLICATE_EN, out-of-frame neighbours shall be 12'h000.

Structure
REQ-027 Shared package window_pkg shall hold:
- PIX_W=12, WIN_W=108;
- the nine slot offset constants (ORIG_LSB=96 ... DR_LSB=0);
- the state enum type.
REQ-028 Sub-module line_buffer (one write and one read port, depth IMG_WIDTH, 12 bits wide, registered read) shall be instantiated twice.

Verification (IMG_WIDTH=4, IMG_HEIGHT=3, pixel value = raster index 0..11, pixel_valid continuously high)
REQ-029 Zero border: first window_valid occurs one cycle after index 5 is accepted. Expected: original=0, right=1, down=4, downright=5, all other slots 0.
REQ-030 BORDER_REPLICATE_EN, first window. Expected: upleft=0, up=0, upright=1, left=0, original=0, right=1, downleft=4, down=4, downright=5.
REQ-031 Zero border, last window (FLUSH cycle 5) with win_last=1. Expected: upleft=6, up=7, left=10, original=11, all other slots 0. Exactly 12 window_valid pulses; in_ready=0 for 5 cycles.
REQ-032 Right-edge window centred at (3,1), zero border. Expected: upleft=2, up=3, left=6, original=7, downleft=10, down=11, upright=right=downright=0.
REQ-033 Aborts and stalls:
- reset asserted after index 7 -> all outputs 0 and no further windows.
- frame_start at index 7 -> the next window is the new (0,0) window, after 5 further accepted pixels.
- random pixel_valid gaps -> window sequence identical to the gap-free run.
